// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-enabled data memory: access sizes, FSM states
// and the alignment/legality rule used by the MEM-stage memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: replicates store data across byte lanes, builds
// byte enables, and extracts/extends the addressed byte or half on loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_sext,
  input  logic [31:0] i_wd,
  input  logic [31:0] i_word,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wdata = i_wd;
    o_be    = 4'b0000;
    case (i_size)
      SZ_BYTE: begin
        o_wdata = {4{i_wd[7:0]}};
        o_be    = 4'b0001 << i_off;
      end
      SZ_HALF: begin
        o_wdata = {2{i_wd[15:0]}};
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        o_wdata = i_wd;
        o_be    = 4'b1111;
      end
      default: begin
        o_wdata = i_wd;
        o_be    = 4'b0000;
      end
    endcase
  end

  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  // Word loads pass straight through; SEXT only matters for sub-word sizes.
  always_comb begin
    o_rdata = i_word;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{i_sext & w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = {{16{i_sext & w_half[15]}}, w_half};
      default: o_rdata = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory_be.sv
// Single-port MEM-stage data memory with byte enables, registered sub-word loads,
// misalignment flagging and a post-reset clear sweep.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing word clr_idx each cycle; busy=1, requests ignored
// ST_READY | servicing loads/stores
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EN,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        SEXT,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        rd_valid,
  output logic        misalign,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0]    ST_RESET = INIT_CLEAR ? ST_CLEAR : ST_READY;
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  logic [31:0]   r_mem [DEPTH];
  logic [0:0]    r_state;
  logic [AW-1:0] r_clr_idx;

  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic          w_legal;
  logic          w_ready;
  logic          w_acc;
  logic          w_st;
  logic          w_ld;
  logic          w_ill;
  logic          w_clr_we;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic [31:0]   w_rdata;
  logic          w_unused_addr;

  assign w_idx         = A[AW+1:2];
  assign w_off         = A[1:0];
  assign w_unused_addr = ^A[31:AW+2];
  assign w_legal       = is_legal(SIZE, w_off);
  assign w_ready       = (r_state == ST_READY);
  assign w_acc         = w_ready & EN;
  assign w_st          = w_acc & WE & w_legal;
  assign w_ld          = w_acc & ~WE & w_legal;
  assign w_ill         = w_acc & ~w_legal;
  // Held off while rst_n is low so reset alone never disturbs the array.
  assign w_clr_we      = (r_state == ST_CLEAR) & rst_n;
  assign busy          = ~w_ready;

  dmem_lane_align u_lane (
    .i_size  (SIZE),
    .i_off   (w_off),
    .i_sext  (SEXT),
    .i_wd    (WD),
    .i_word  (r_mem[w_idx]),
    .o_wdata (w_wdata),
    .o_be    (w_be),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_clr_idx <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_idx == IDX_LAST) r_state <= ST_READY;
      r_clr_idx <= r_clr_idx + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_st) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RD       <= '0;
      rd_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rd_valid <= w_ld;
      misalign <= w_ill;
      if (w_ld) RD <= w_rdata;
    end
  end

endmodule
